// File: rtl/wr_buf_burst_ctrl.sv
// rtl/wr_buf_burst_ctrl.sv - drains filled write-buffer halves as DDR write bursts across rotating frame stores
// Optional sticky overflow flag enabled by defining WR_BUF_CTRL_OVF_EN.
module wr_buf_burst_ctrl #(
    parameter int          RD_ADDR_WIDTH = 8,
    parameter int          DATA_WIDTH    = 128,
    parameter int          BURST_LEN     = 128,
    parameter int          ADDR_WIDTH    = 28,
    parameter logic [63:0] BASE_ADDR     = 64'd0,
    parameter logic [31:0] FRAME_STRIDE  = 32'h0020_0000,
    parameter int          FRAME_BURSTS  = 900,
    parameter int          FB_NUM        = 2
) (
    input  logic                     rd_clk,
    input  logic                     rd_rst,
    input  logic                     half_rdy,
    input  logic                     frame_start,
    output logic [RD_ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     awvalid,
    input  logic                     awready,
    output logic [ADDR_WIDTH-1:0]    awaddr,
    output logic [7:0]               awlen,
    output logic                     wvalid,
    input  logic                     wready,
    output logic [DATA_WIDTH-1:0]    wdata,
    output logic                     wlast,
    output logic                     frame_done,
    output logic [1:0]               wr_frame_idx,
    output logic                     ovf
);

    localparam int BC_W = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;
    localparam int RC_W = $clog2(BURST_LEN + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_AW   = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [1:0]            state;
    logic [1:0]            pending;
    logic                  half;
    logic                  resync;
    logic [BC_W-1:0]       burst_cnt;
    logic [RC_W-1:0]       rd_cnt;
    logic [7:0]            beat_cnt;
    logic                  rd_pend;
    logic                  skid_vld;
    logic [DATA_WIDTH-1:0] skid_data;

    logic                  w_hs;
    logic                  last_hs;
    logic                  in_burst;
    logic                  issue;
    logic                  inc;
    logic                  out_free;
    logic [1:0]            fill;
    logic [ADDR_WIDTH-1:0] next_awaddr;

    assign awlen = 8'(BURST_LEN - 1);
    assign wlast = wvalid && (beat_cnt == 8'(BURST_LEN - 1));

    always_comb begin
        w_hs     = wvalid && wready;
        last_hs  = w_hs && wlast;
        in_burst = (state == S_AW && awready) || (state == S_DATA);
        out_free = !wvalid || wready;
        inc      = half_rdy && (pending != 2'd2);
        // Entries held or on their way: output register, skid register, read in flight.
        fill     = {1'b0, wvalid} + {1'b0, skid_vld} + {1'b0, rd_pend};
        issue    = in_burst && (rd_cnt != RC_W'(BURST_LEN)) &&
                   ((fill < 2'd2) || (fill == 2'd2 && w_hs));
        next_awaddr = ADDR_WIDTH'(BASE_ADDR
                    + 64'(wr_frame_idx) * 64'(FRAME_STRIDE)
                    + 64'(burst_cnt) * 64'(BURST_LEN * (DATA_WIDTH / 8)));
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state        <= S_IDLE;
            pending      <= 2'd0;
            half         <= 1'b0;
            resync       <= 1'b0;
            burst_cnt    <= '0;
            rd_cnt       <= '0;
            rd_addr      <= '0;
            awvalid      <= 1'b0;
            awaddr       <= ADDR_WIDTH'(BASE_ADDR);
            frame_done   <= 1'b0;
            wr_frame_idx <= 2'd0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (resync) begin
                        burst_cnt <= '0;
                        half      <= 1'b0;
                    end else if (pending != 2'd0) begin
                        state   <= S_AW;
                        awvalid <= 1'b1;
                        awaddr  <= next_awaddr;
                        rd_addr <= half ? RD_ADDR_WIDTH'(BURST_LEN) : '0;
                        rd_cnt  <= '0;
                    end
                end
                S_AW: begin
                    if (awready) begin
                        awvalid <= 1'b0;
                        state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (last_hs) begin
                        state <= S_IDLE;
                        half  <= ~half;
                        if (burst_cnt == BC_W'(FRAME_BURSTS - 1)) begin
                            burst_cnt    <= '0;
                            frame_done   <= 1'b1;
                            wr_frame_idx <= (wr_frame_idx == 2'(FB_NUM - 1)) ? 2'd0 : wr_frame_idx + 2'd1;
                        end else begin
                            burst_cnt <= burst_cnt + BC_W'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (issue) begin
                rd_addr <= rd_addr + RD_ADDR_WIDTH'(1);
                rd_cnt  <= rd_cnt + RC_W'(1);
            end

            if (frame_start)
                resync <= 1'b1;
            else if (state == S_IDLE)
                resync <= 1'b0;

            // A resync discards queued halves; only one arriving in the same cycle survives.
            if (state == S_IDLE && resync)
                pending <= {1'b0, half_rdy};
            else if (inc && !last_hs)
                pending <= pending + 2'd1;
            else if (!inc && last_hs)
                pending <= pending - 2'd1;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            rd_pend   <= 1'b0;
            wvalid    <= 1'b0;
            wdata     <= '0;
            skid_vld  <= 1'b0;
            skid_data <= '0;
            beat_cnt  <= 8'd0;
        end else begin
            rd_pend <= issue;
            if (out_free) begin
                if (skid_vld) begin
                    wdata    <= skid_data;
                    wvalid   <= 1'b1;
                    skid_vld <= rd_pend;
                    if (rd_pend)
                        skid_data <= rd_data;
                end else if (rd_pend) begin
                    wdata  <= rd_data;
                    wvalid <= 1'b1;
                end else begin
                    wvalid <= 1'b0;
                end
            end else if (rd_pend) begin
                skid_data <= rd_data;
                skid_vld  <= 1'b1;
            end
            if (w_hs)
                beat_cnt <= last_hs ? 8'd0 : beat_cnt + 8'd1;
        end
    end

`ifdef WR_BUF_CTRL_OVF_EN
    always_ff @(posedge rd_clk) begin
        if (rd_rst)
            ovf <= 1'b0;
        else if (half_rdy && pending == 2'd2)
            ovf <= 1'b1;
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_wr_buf_burst_ctrl.sv
// tb/tb_wr_buf_burst_ctrl.sv - directed bench for wr_buf_burst_ctrl with buffer RAM model and beat monitor
module tb_wr_buf_burst_ctrl;

    localparam int BL      = 128;
    localparam int DW      = 128;
    localparam int AW      = 28;
    localparam int FBURSTS = 6;

    logic          rd_clk = 1'b0;
    logic          rd_rst;
    logic          half_rdy;
    logic          frame_start;
    logic [7:0]    rd_addr;
    logic [DW-1:0] rd_data;
    logic          awvalid;
    logic          awready;
    logic [AW-1:0] awaddr;
    logic [7:0]    awlen;
    logic          wvalid;
    logic          wready;
    logic [DW-1:0] wdata;
    logic          wlast;
    logic          frame_done;
    logic [1:0]    wr_frame_idx;
    logic          ovf;

    always #5 rd_clk = ~rd_clk;

    wr_buf_burst_ctrl #(
        .RD_ADDR_WIDTH (8),
        .DATA_WIDTH    (DW),
        .BURST_LEN     (BL),
        .ADDR_WIDTH    (AW),
        .BASE_ADDR     (64'd0),
        .FRAME_STRIDE  (32'h0020_0000),
        .FRAME_BURSTS  (FBURSTS),
        .FB_NUM        (2)
    ) dut (
        .rd_clk       (rd_clk),
        .rd_rst       (rd_rst),
        .half_rdy     (half_rdy),
        .frame_start  (frame_start),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .awvalid      (awvalid),
        .awready      (awready),
        .awaddr       (awaddr),
        .awlen        (awlen),
        .wvalid       (wvalid),
        .wready       (wready),
        .wdata        (wdata),
        .wlast        (wlast),
        .frame_done   (frame_done),
        .wr_frame_idx (wr_frame_idx),
        .ovf          (ovf)
    );

    logic [DW-1:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++)
            mem[i] = {32'hC0DE_0000 + 32'(i), 32'(i * 7 + 3), ~32'(i), 32'(i)};
    end
    always @(posedge rd_clk) rd_data <= mem[rd_addr];

    int vec_cnt = 0;
    int err_cnt = 0;

    int cyc = 0, done_cnt = 0, beat_idx = 0, last_beats = 0;
    int data_err = 0, last_err = 0, stab_err = 0, aw_stab_err = 0;
    int fd_cnt = 0, stall_cnt = 0;
    int aw_hs_cyc = 0, first_hs_cyc = 0, last_w_cyc = 0, awv_rise_cyc = 0, aw_gap = 0, hr_cyc = 0;
    logic [AW-1:0] cur_aw_addr = '0, done_aw_addr = '0, prev_awaddr = '0;
    logic [7:0]    cur_rd_base = '0, done_rd_base = '0;
    logic [DW-1:0] prev_wdata = '0;
    logic prev_w_stall = 1'b0, prev_aw_stall = 1'b0, prev_awv = 1'b0;
    logic aw_hold = 1'b0, w_rand = 1'b0;
    logic exp_ovf;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        vec_cnt++;
        if (got !== want) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // One clock: clears pulses, drives ready lines for the next edge and records handshakes.
    task automatic tick();
        logic       in_rst;
        logic [7:0] a;
        @(negedge rd_clk);
        cyc++;
        in_rst      = rd_rst;
        rd_rst      = 1'b0;
        half_rdy    = 1'b0;
        frame_start = 1'b0;
        if (in_rst) begin
            beat_idx      = 0;
            prev_w_stall  = 1'b0;
            prev_aw_stall = 1'b0;
            prev_awv      = 1'b0;
        end else begin
            if (prev_w_stall && (!wvalid || wdata !== prev_wdata)) stab_err++;
            if (prev_aw_stall && (!awvalid || awaddr !== prev_awaddr)) aw_stab_err++;
        end
        if (frame_done) fd_cnt++;
        if (awvalid && !prev_awv) awv_rise_cyc = cyc;
        prev_awv = awvalid;
        awready  = !aw_hold;
        wready   = w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (awvalid && awready) begin
            aw_hs_cyc   = cyc;
            aw_gap      = cyc - last_w_cyc;
            cur_aw_addr = awaddr;
            cur_rd_base = rd_addr;
            beat_idx    = 0;
        end
        if (wvalid && !wready) stall_cnt++;
        if (wvalid && wready) begin
            if (beat_idx == 0) first_hs_cyc = cyc;
            a = cur_rd_base + 8'(beat_idx);
            if (wdata !== mem[a]) data_err++;
            if (wlast !== (beat_idx == BL - 1)) last_err++;
            beat_idx++;
            if (wlast) begin
                done_cnt++;
                last_beats   = beat_idx;
                last_w_cyc   = cyc;
                done_aw_addr = cur_aw_addr;
                done_rd_base = cur_rd_base;
            end
        end
        prev_w_stall  = wvalid && !wready;
        prev_wdata    = wdata;
        prev_aw_stall = awvalid && !awready;
        prev_awaddr   = awaddr;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 2000) begin
            tick();
            n++;
        end
        chk("burst_done", 64'(done_cnt), 64'(target));
    endtask

    task automatic check_burst(input logic [AW-1:0] exp_addr, input logic [7:0] exp_rd);
        chk("awaddr", 64'(done_aw_addr), 64'(exp_addr));
        chk("rd_addr_start", 64'(done_rd_base), 64'(exp_rd));
        chk("beats", 64'(last_beats), 64'(BL));
        chk("wdata_err", 64'(data_err), 64'd0);
        chk("wlast_err", 64'(last_err), 64'd0);
    endtask

    task automatic do_burst(input logic [AW-1:0] exp_addr, input logic [7:0] exp_rd);
        int target;
        target   = done_cnt + 1;
        hr_cyc   = cyc;
        half_rdy = 1'b1;
        wait_done(target);
        check_burst(exp_addr, exp_rd);
    endtask

    task automatic check_reset_outputs();
        chk("rst_awvalid", 64'(awvalid), 64'd0);
        chk("rst_wvalid", 64'(wvalid), 64'd0);
        chk("rst_wlast", 64'(wlast), 64'd0);
        chk("rst_awaddr", 64'(awaddr), 64'd0);
        chk("rst_awlen", 64'(awlen), 64'd127);
        chk("rst_rd_addr", 64'(rd_addr), 64'd0);
        chk("rst_wdata", 64'(wdata[63:0]), 64'd0);
        chk("rst_wdata_hi", 64'(wdata[127:64]), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_frame_idx", 64'(wr_frame_idx), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
    endtask

    initial begin
`ifdef WR_BUF_CTRL_OVF_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        rd_rst      = 1'b1;
        half_rdy    = 1'b0;
        frame_start = 1'b0;
        awready     = 1'b0;
        wready      = 1'b0;
        tick();
        check_reset_outputs();
        tick();

        // First burst: latencies, addresses and a back-to-IDLE quiet bus.
        do_burst(28'h000_0000, 8'd0);
        chk("aw_latency", 64'(awv_rise_cyc - hr_cyc), 64'd2);
        chk("w_latency", 64'(first_hs_cyc - aw_hs_cyc), 64'd2);
        chk("burst_cycles", 64'(last_w_cyc - first_hs_cyc), 64'(BL - 1));
        chk("awlen", 64'(awlen), 64'd127);
        repeat (3) tick();
        chk("idle_awvalid", 64'(awvalid), 64'd0);

        do_burst(28'h000_0800, 8'd128);

        // Random back-pressure on the data channel.
        w_rand = 1'b1;
        do_burst(28'h000_1000, 8'd0);
        w_rand = 1'b0;
        chk("wdata_stable_err", 64'(stab_err), 64'd0);
        chk("stalls_seen", 64'(stall_cnt > 0), 64'd1);

        // Three halves queued behind a stalled address channel.
        aw_hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            half_rdy = 1'b1;
            tick();
            tick();
        end
        chk("ovf", 64'(ovf), 64'(exp_ovf));
        chk("aw_held_valid", 64'(awvalid), 64'd1);
        chk("aw_held_addr", 64'(awaddr), 64'h1800);
        chk("no_burst_held", 64'(done_cnt), 64'd3);
        aw_hold = 1'b0;
        wait_done(4);
        check_burst(28'h000_1800, 8'd128);
        wait_done(5);
        check_burst(28'h000_2000, 8'd0);
        chk("b2b_aw_gap", 64'(aw_gap), 64'd2);
        chk("aw_stable_err", 64'(aw_stab_err), 64'd0);
        repeat (300) tick();
        chk("no_extra_burst", 64'(done_cnt), 64'd5);
        chk("ovf_sticky", 64'(ovf), 64'(exp_ovf));

        // Frame wrap into store 1.
        do_burst(28'h000_2800, 8'd128);
        tick();
        tick();
        chk("frame_done_cnt1", 64'(fd_cnt), 64'd1);
        chk("frame_idx1", 64'(wr_frame_idx), 64'd1);
        do_burst(28'h020_0000, 8'd0);

        // Resync restarts the frame and the half pointer.
        frame_start = 1'b1;
        tick();
        do_burst(28'h020_0000, 8'd0);
        chk("resync_frame_idx", 64'(wr_frame_idx), 64'd1);
        for (int k = 1; k <= 5; k++)
            do_burst(28'h020_0000 + 28'(k * 32'h800), (k % 2 == 1) ? 8'd128 : 8'd0);
        tick();
        tick();
        chk("frame_done_cnt2", 64'(fd_cnt), 64'd2);
        chk("frame_idx0", 64'(wr_frame_idx), 64'd0);

        // Reset in the middle of a burst.
        half_rdy = 1'b1;
        for (int n = 0; n < 1000 && beat_idx != 50; n++)
            tick();
        chk("beat50_reached", 64'(beat_idx), 64'd50);
        rd_rst = 1'b1;
        tick();
        check_reset_outputs();
        frame_start = 1'b1;
        tick();
        do_burst(28'h000_0000, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
